// File: rtl/seg7_capture_decode.sv
// Seven-segment capture: synchronizes, debounces and decodes segment lines to a hex digit.
// Optional countdown-order checker built when SEG7_CAPTURE_SEQ_CHECK_EN is defined.
module seg7_capture_decode #(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       err,
  output logic [7:0] err_pattern,
  output logic       seq_err,
  output logic [7:0] seq_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [7:0]       last_pat_q, last_pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic [7:0]       err_pattern_q, err_pattern_d;
  logic             accept, dec_legal;
  logic [3:0]       dec_digit;

  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'h0;
    case (sync2_q)
      8'hEE: dec_digit = 4'h0;
      8'h28: dec_digit = 4'h1;
      8'hCD: dec_digit = 4'h2;
      8'h6D: dec_digit = 4'h3;
      8'h2B: dec_digit = 4'h4;
      8'h67: dec_digit = 4'h5;
      8'hE7: dec_digit = 4'h6;
      8'h2C: dec_digit = 4'h7;
      8'hEF: dec_digit = 4'h8;
      8'h6F: dec_digit = 4'h9;
      8'hAF: dec_digit = 4'hA;
      8'hE3: dec_digit = 4'hB;
      8'hC6: dec_digit = 4'hC;
      8'hE9: dec_digit = 4'hD;
      8'hC7: dec_digit = 4'hE;
      8'h87: dec_digit = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Accept fires once per stable period: cnt passes ACCEPT_AT only once before saturating.
  assign accept = (cnt_q == ACCEPT_AT) && (sync2_q == prev_q) && (sync2_q != last_pat_q);

  always_comb begin
    sync1_d       = seg_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    cnt_d         = cnt_q;
    last_pat_d    = last_pat_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    blank_d       = blank_q;
    err_d         = 1'b0;
    err_pattern_d = err_pattern_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (accept) begin
      last_pat_d = sync2_q;
      if (dec_legal) begin
        digit_d       = dec_digit;
        digit_valid_d = 1'b1;
        blank_d       = 1'b0;
      end else if (sync2_q == 8'h00) begin
        blank_d = 1'b1;
      end else begin
        err_d         = 1'b1;
        err_pattern_d = sync2_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
      last_pat_q    <= '0;
      cnt_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b1;
      err_q         <= 1'b0;
      err_pattern_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      last_pat_q    <= last_pat_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      err_pattern_q <= err_pattern_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign err_pattern = err_pattern_q;

`ifdef SEG7_CAPTURE_SEQ_CHECK_EN
  logic       have_prev_q, have_prev_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] seq_err_cnt_q, seq_err_cnt_d;

  always_comb begin
    have_prev_d   = have_prev_q;
    seq_err_d     = 1'b0;
    seq_err_cnt_d = seq_err_cnt_q;
    if (accept) begin
      if (dec_legal) begin
        have_prev_d = 1'b1;
        if (have_prev_q && (dec_digit != digit_q - 4'd1)) begin
          seq_err_d = 1'b1;
          if (seq_err_cnt_q != 8'hFF) begin
            seq_err_cnt_d = seq_err_cnt_q + 8'd1;
          end
        end
      end else begin
        have_prev_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev_q   <= 1'b0;
      seq_err_q     <= 1'b0;
      seq_err_cnt_q <= '0;
    end else begin
      have_prev_q   <= have_prev_d;
      seq_err_q     <= seq_err_d;
      seq_err_cnt_q <= seq_err_cnt_d;
    end
  end

  assign seq_err     = seq_err_q;
  assign seq_err_cnt = seq_err_cnt_q;
`else
  assign seq_err     = 1'b0;
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg7_capture_decode.sv
// Directed bench for seg7_capture_decode with STABLE_CYCLES=4; seq expectations follow SEG7_CAPTURE_SEQ_CHECK_EN.
module tb_seg7_capture_decode;

`ifdef SEG7_CAPTURE_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic [3:0] digit;
  logic       digit_valid, blank, err, seq_err;
  logic [7:0] err_pattern, seq_err_cnt;

  int checks = 0;
  int failures = 0;
  int n_valid, n_seq, n_err, n_overlap;

  always #5 clk = ~clk;

  seg7_capture_decode #(
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .blank(blank),
    .err(err),
    .err_pattern(err_pattern),
    .seq_err(seq_err),
    .seq_err_cnt(seq_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_valid = 0; n_seq = 0; n_err = 0; n_overlap = 0;
  endtask

  // Drive a pattern on a falling edge and observe n rising edges, tallying pulses.
  task automatic hold(input logic [7:0] pat, input int unsigned n);
    @(negedge clk);
    seg_in = pat;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (digit_valid) n_valid++;
      if (seq_err) n_seq++;
      if (err) n_err++;
      if ((err && (digit_valid || seq_err)) || (seq_err && !digit_valid)) n_overlap++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digit"}, 32'(digit), 32'h0);
    chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h1);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_errpat"}, 32'(err_pattern), 32'h0);
    chk({tag, "_seq"}, 32'(seq_err), 32'h0);
    chk({tag, "_seqcnt"}, 32'(seq_err_cnt), 32'h0);
  endtask

  logic [7:0] countdown [17];
  logic [3:0] exp_digit;

  initial begin
    countdown = '{8'h87, 8'hC7, 8'hE9, 8'hC6, 8'hE3, 8'hAF, 8'h6F, 8'hEF, 8'h2C,
                  8'hE7, 8'h67, 8'h2B, 8'h6D, 8'hCD, 8'h28, 8'hEE, 8'h87};
    clr_counts();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");

    // First accept latency: pulse exactly at E0+6
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seg_in = 8'h87;
    repeat (6) @(posedge clk);
    #1;
    chk("lat_early_valid", 32'(digit_valid), 32'h0);
    chk("lat_early_blank", 32'(blank), 32'h1);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(digit_valid), 32'h1);
    chk("lat_digit", 32'(digit), 32'hF);
    chk("lat_blank", 32'(blank), 32'h0);
    chk("lat_seq", 32'(seq_err), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_valid_drop", 32'(digit_valid), 32'h0);

    // Blank, then full countdown F..0,F
    clr_counts();
    hold(8'h00, 20);
    chk("blank_set", 32'(blank), 32'h1);
    chk("blank_nopulse", 32'(n_valid + n_err + n_seq), 32'h0);
    chk("blank_digit_held", 32'(digit), 32'hF);
    clr_counts();
    exp_digit = 4'hF;
    for (int i = 0; i < 17; i++) begin
      hold(countdown[i], 20);
      chk($sformatf("cd_digit%0d", i), 32'(digit), 32'(exp_digit));
      exp_digit = exp_digit - 4'd1;
    end
    chk("cd_valid_cnt", 32'(n_valid), 32'd17);
    chk("cd_seq_cnt", 32'(n_seq), 32'd0);
    chk("cd_err_cnt", 32'(n_err), 32'd0);

    // Glitch rejection around a held 0
    hold(8'h00, 20);
    hold(8'hEE, 20);
    chk("gl_pre_digit", 32'(digit), 32'h0);
    clr_counts();
    hold(8'h6F, 3);
    hold(8'hEE, 20);
    chk("gl_nopulse", 32'(n_valid + n_err + n_seq), 32'h0);
    chk("gl_digit", 32'(digit), 32'h0);
    chk("gl_blank", 32'(blank), 32'h0);

    // Countdown violations: 0 -> F legal, F -> 3 and 3 -> 1 illegal
    clr_counts();
    hold(8'h87, 20);
    chk("v_f_seq", 32'(n_seq), 32'd0);
    chk("v_f_digit", 32'(digit), 32'hF);
    clr_counts();
    hold(8'h6D, 20);
    chk("v_3_digit", 32'(digit), 32'h3);
    chk("v_3_valid", 32'(n_valid), 32'd1);
    chk("v_3_seq", 32'(n_seq), SEQ_EN ? 32'd1 : 32'd0);
    chk("v_3_seqcnt", 32'(seq_err_cnt), SEQ_EN ? 32'd1 : 32'd0);
    chk("v_3_overlap", 32'(n_overlap), 32'd0);
    clr_counts();
    hold(8'h28, 20);
    chk("v_1_digit", 32'(digit), 32'h1);
    chk("v_1_seq", 32'(n_seq), SEQ_EN ? 32'd1 : 32'd0);
    chk("v_1_seqcnt", 32'(seq_err_cnt), SEQ_EN ? 32'd2 : 32'd0);

    // Illegal pattern, blank, then fresh digit without seq_err
    clr_counts();
    hold(8'h55, 20);
    chk("e_err_cnt", 32'(n_err), 32'd1);
    chk("e_err_pat", 32'(err_pattern), 32'h55);
    chk("e_digit", 32'(digit), 32'h1);
    chk("e_valid", 32'(n_valid), 32'd0);
    chk("e_blank", 32'(blank), 32'h0);
    clr_counts();
    hold(8'h00, 20);
    chk("e_blank_set", 32'(blank), 32'h1);
    chk("e_blank_nopulse", 32'(n_valid + n_err + n_seq), 32'h0);
    clr_counts();
    hold(8'h2B, 20);
    chk("e_4_digit", 32'(digit), 32'h4);
    chk("e_4_valid", 32'(n_valid), 32'd1);
    chk("e_4_seq", 32'(n_seq), 32'd0);
    chk("e_4_blank", 32'(blank), 32'h0);
    chk("e_seqcnt_kept", 32'(seq_err_cnt), SEQ_EN ? 32'd2 : 32'd0);
    chk("all_overlap", 32'(n_overlap), 32'd0);

    // Asynchronous reset mid-count, then full latency after release
    @(negedge clk);
    seg_in = 8'h6D;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_early_valid", 32'(digit_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("post_valid", 32'(digit_valid), 32'h1);
    chk("post_digit", 32'(digit), 32'h3);
    chk("post_seq", 32'(seq_err), 32'h0);
    @(posedge clk);
    #1;
    chk("post_valid_drop", 32'(digit_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
